channel_scanner: RTL
====================

CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 Parameter DWELL, default 4, sets the number of clock cycles each selected channel is held; legal range 1..255.
REQ-002 The block SHALL provide the following ports:
  clk  input  1  sole clock; all state updates on rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  start  input  1  request one scan pass; sampled only in IDLE.
  chan_en  input  7  per-channel enable mask; bit k enables mux input k.
  sel  output  3  select driven to the downstream 7:1 mux select input.
  sel_valid  output  1  high while sel addresses a channel under scan.
  sample  output  1  one-cycle strobe; mux output is stable and is to be captured this cycle.
  busy  output  1  high in SCAN and DONE states.
  done  output  1  one-cycle pulse marking end of pass.

Function
REQ-003 The block SHALL implement three states: IDLE, SCAN and DONE.
REQ-004 In IDLE, start=1 SHALL latch chan_en into an internal mask on the same edge; later chan_en changes SHALL have no effect until the next start.
REQ-005 If the latched mask is nonzero, the block SHALL enter SCAN on the next cycle with sel = lowest enabled index, sel_valid=1 and dwell counter=0.
REQ-006 If the latched mask is zero, the block SHALL go IDLE -> DONE -> IDLE, and sel_valid and sample SHALL never assert.
REQ-007 In SCAN, the dwell counter SHALL increment every cycle; sample SHALL be 1 exactly when counter = DWELL-1.
REQ-008 On the sample cycle, the block SHALL advance sel to the next higher enabled index and reset the counter to 0; disabled indices SHALL be skipped with no dead cycles.
REQ-009 If no higher enabled index exists, on the sample cycle the block SHALL move to DONE; sel_valid SHALL drop on the following cycle.
REQ-010 DONE SHALL last exactly one cycle with done=1, sel_valid=0 and sample=0, then return to IDLE.
REQ-011 sel SHALL never take the value 3'b111; when sel_valid=0, sel SHALL be 3'b000.
REQ-012 With DWELL=1, sample SHALL be high on every SCAN cycle and sel SHALL change every cycle.
REQ-013 start asserted outside IDLE, including during the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-014 Each pass SHALL visit channels in ascending order only, and each enabled channel exactly once.
REQ-015 The dwell counter SHALL be 8 bits wide; wrap-around SHALL be unreachable because of REQ-007 and REQ-008.
REQ-016 Outputs SHALL be registered (glitch-free); latency from the start edge to first sel_valid=1 SHALL be one cycle.

Reset
REQ-017 rst_n=0 SHALL immediately force state=IDLE, sel=0, sel_valid=0, sample=0, busy=0, done=0, latched mask=0 and counter=0, independent of clk.
REQ-018 Reset asserted mid-scan SHALL abort the pass with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-019 A start coincident with the first clock edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-020 DWELL=4, chan_en=7'b1010101, start pulsed at edge 0 -> sel=0,2,4,6 each held 4 cycles (cycles 1-16), sample at cycles 4,8,12,16, done at cycle 17, busy cycles 1-17.
REQ-021 chan_en=7'b0000000, start -> done at cycle 1 only, sel_valid and sample never high, IDLE at cycle 2.
REQ-022 DWELL=1, chan_en=7'b1111111 -> sel=0..6 on consecutive cycles 1-7, sample high cycles 1-7, done at cycle 8.
REQ-023 chan_en=7'b1000000, then chan_en changed to 7'b0000001 and start re-pulsed at cycle 2 -> only sel=6 scanned for DWELL cycles, the second start is ignored, and done fires once.
REQ-024 DWELL=4, chan_en=7'b1010101, rst_n pulsed low at cycle 6 -> all outputs 0 immediately with no done pulse; a new start after release restarts the scan at sel=0.
REQ-025 Scoreboard over all runs -> sel never 7, sample count equals popcount(mask) per pass, and sel matches the ascending enabled index sequence.

Source files
------------

// File: rtl/channel_scanner_if.sv
// Handshake bundle between a scan controller and the channel scanner:
// pass request and enable mask in, mux select and pass status out.
interface channel_scanner_if;
  logic       start;
  logic [6:0] chan_en;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sample;
  logic       busy;
  logic       done;

  modport master (
    output start, chan_en,
    input  sel, sel_valid, sample, busy, done
  );

  modport slave (
    input  start, chan_en,
    output sel, sel_valid, sample, busy, done
  );
endinterface

// File: rtl/channel_scanner.sv
// Steps a 7:1 mux select through the enabled channels in ascending order,
// holding each for DWELL cycles and strobing sample on the last held cycle.
module channel_scanner #(
  parameter int DWELL = 4
) (
  input logic         clk,
  input logic         rst_n,
  channel_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] LAST_CNT     = 8'(DWELL - 1);
  localparam logic       FIRST_SAMPLE = (DWELL == 1);

  state_t     state_q;
  logic [6:0] mask_q;
  logic [7:0] cnt_q;
  logic [2:0] sel_q;
  logic       sel_valid_q;
  logic       sample_q;
  logic       busy_q;
  logic       done_q;

  logic [3:0] first_hit;
  logic [3:0] next_hit;

  // {found, index} of the lowest enabled channel at or above 'from'
  function automatic logic [3:0] find_from(input logic [6:0] m, input logic [2:0] from);
    logic [3:0] hit;
    hit = '0;
    for (int k = 6; k >= 0; k--) begin
      if (m[k] && (3'(k) >= from)) hit = {1'b1, 3'(k)};
    end
    return hit;
  endfunction

  // sel_q + 1 wraps to 7 after channel 6, which never matches, so the pass ends
  assign first_hit = find_from(bus.chan_en, 3'd0);
  assign next_hit  = find_from(mask_q, sel_q + 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mask_q <= bus.chan_en;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (first_hit[3]) begin
              state_q     <= SCAN;
              sel_q       <= first_hit[2:0];
              sel_valid_q <= 1'b1;
              sample_q    <= FIRST_SAMPLE;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (next_hit[3]) begin
              sel_q    <= next_hit[2:0];
              sample_q <= FIRST_SAMPLE;
            end else begin
              state_q     <= DONE;
              sel_q       <= '0;
              sel_valid_q <= 1'b0;
              sample_q    <= 1'b0;
              done_q      <= 1'b1;
            end
          end else begin
            // sample is registered, so it is raised on the edge entering the last dwell cycle
            cnt_q    <= cnt_q + 8'd1;
            sample_q <= ((cnt_q + 8'd1) == LAST_CNT);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          sel_q       <= '0;
          sel_valid_q <= 1'b0;
          sample_q    <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sample    = sample_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
